div_iter: RTL and testbench
===========================

# div_iter

Iterative signed 32-bit integer divider core for the signed integer divider datapath. It sits directly downstream of the leading-sign normalizing shifter. It takes a dividend, a divisor and the dividend's redundant-sign-bit count from that shifter, and returns a truncating (round-toward-zero) quotient and remainder. Operation is a multi-cycle radix-2 restoring loop on magnitudes, with a valid/ready handshake on both sides.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: high only in IDLE with `rst` low.
- `dividend` input 32: signed dividend.
- `divisor` input 32: signed divisor.
- `dvd_shift` input 5: redundant sign bits of `dividend`, 0..31, taken from the upstream shifter's shift count.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `quotient` output 32: signed quotient, registered.
- `remainder` output 32: signed remainder, registered.
- `div_by_zero` output 1: result is from a zero divisor, registered.

## Operation
- FSM states are IDLE, CALC and DONE.
- Reset values: state IDLE, `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. All internal registers clear.
- **Accept:** accept occurs on `in_valid && in_ready`.
  - Latch `|dividend|` as 32-bit unsigned, so 0x80000000 maps to 2^31.
  - Latch `|divisor|`, `q_neg = dividend[31]^divisor[31]` and `r_neg = dividend[31]`.
  - Clear the 33-bit partial remainder R.
  - Load the iteration counter with N (see Configuration).
  - Go to CALC, or go straight to DONE if `divisor`==0.
- **CALC iteration:** one iteration per cycle.
  - Compute T = {R[31:0], Q[31]} − |divisor| in 33 bits.
  - If T ≥ 0: R=T and shift 1 into Q; else R={R[31:0],Q[31]} and shift 0 into Q.
  - Q also shifts left each cycle.
  - After the N-th iteration, in the same edge, register the signed results and go to DONE:
    - `quotient` = q_neg ? −Q : Q
    - `remainder` = r_neg ? −R[31:0] : R[31:0]
- **Divide by zero:** `quotient`=0xFFFFFFFF, `remainder`=`dividend`, `div_by_zero`=1. No iterations are run.
- **Overflow:** 0x80000000 / 0xFFFFFFFF needs no special case. Magnitude arithmetic yields `quotient`=0x80000000, `remainder`=0, `div_by_zero`=0.
- **DONE:**
  - `out_valid`=1; outputs stay stable until `out_ready`.
  - On `out_valid && out_ready`, `out_valid` falls and the block returns to IDLE.
  - Outputs keep their values after the handshake.
- Only one operation is in flight. `in_ready`=0 in CALC and DONE, so there is no accept in the same cycle as result handoff.

## Timing
- Let E0 be the accept edge. `out_valid` rises N edges later, where N is the number of CALC iterations.
- Divide-by-zero: `out_valid` is high in the cycle after E0.
- Throughput is one operation per N+2 cycles with `out_ready` tied high: N CALC, 1 DONE, 1 IDLE.
- `in_ready` is combinational from state and `rst`. `out_valid` and the data outputs are registered.
- **Reset mid-operation:** `rst` high at any edge aborts CALC or DONE. No `out_valid` follows, and the outputs clear to their reset values.
- `in_valid` held high during CALC/DONE is ignored. The operand inputs are sampled only at accept.

## Configuration
- Macro: `DIV_ITER_EARLY_TERM_EN`.
- **Defined:** N = 32 − `dvd_shift`, with range 1..32.
  - At accept, Q is loaded with `|dividend| << dvd_shift`.
  - The magnitude of a dividend with s redundant sign bits fits in 32−s bits, so skipped quotient bits are zero.
- **Undefined:** `dvd_shift` is ignored. N = 32 and Q is loaded with `|dividend|`.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- 100 / 7, `dvd_shift`=24, `out_ready`=1:
  - Response: `quotient`=14, `remainder`=2, `div_by_zero`=0.
  - `out_valid` comes 8 cycles after accept with `DIV_ITER_EARLY_TERM_EN` defined, and 32 cycles after accept without it.
- Signs:
  - −100 / 7 → −14, rem −2.
  - 100 / −7 → −14, rem 2.
  - −100 / −7 → 14, rem −2.
- 0x80000000 / 0xFFFFFFFF, `dvd_shift`=0 → `quotient`=0x80000000, `remainder`=0, latency 32.
- 0x12345678 / 0 → `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1, `out_valid` one cycle after accept.
- Backpressure: −1 / 1 with `dvd_shift`=31 (N=1 when early-term is defined), `out_ready` held low for 5 cycles.
  - `out_valid` and `quotient`=0xFFFFFFFF hold and `in_ready` stays 0.
  - Releasing `out_ready` gives IDLE on the next edge.
- Reset at CALC iteration 10 of 1000/3 → no `out_valid`. The next op, 9/3 → 3 rem 0, completes correctly.

Source files
------------

// File: rtl/div_iter_if.sv
// div_iter_if: operand/result handshake bundle for the iterative divider.
interface div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  dvd_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    modport master (
        output in_valid, dividend, divisor, dvd_shift, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, dvd_shift, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring signed 32-bit divider, truncating quotient/remainder.
// DIV_ITER_EARLY_TERM_EN skips the dividend's redundant sign bits (N = 32 - dvd_shift).
module div_iter (
    input logic      clk,
    input logic      rst,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] dvs_q, dvs_d, q_q, q_d, quo_q, quo_d, rem_q, rem_d;
    logic [32:0] r_q, r_d, diff;
    logic [33:0] sh;
    logic [5:0]  cnt_q, cnt_d, n_it;
    logic [31:0] dvd_abs, q_init;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic        ov_q, ov_d, dbz_q, dbz_d, ge, accept;

    assign dvd_abs = bus.dividend[31] ? -bus.dividend : bus.dividend;
`ifdef DIV_ITER_EARLY_TERM_EN
    assign n_it   = 6'd32 - {1'b0, bus.dvd_shift};
    assign q_init = dvd_abs << bus.dvd_shift;
`else
    logic unused_shift;
    assign unused_shift = ^bus.dvd_shift;
    assign n_it   = 6'd32;
    assign q_init = dvd_abs;
`endif

    // Trial subtraction on {R, next dividend bit}; the wide compare avoids sign ambiguity.
    assign sh     = {r_q, q_q[31]};
    assign ge     = sh >= {2'b0, dvs_q};
    assign diff   = sh[32:0] - {1'b0, dvs_q};
    assign accept = state_q == IDLE && bus.in_valid && bus.in_ready;

    assign bus.in_ready    = state_q == IDLE && !rst;
    assign bus.out_valid   = ov_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        ov_d    = ov_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (accept) begin
            dvs_d   = bus.divisor[31] ? -bus.divisor : bus.divisor;
            q_d     = q_init;
            r_d     = '0;
            cnt_d   = n_it;
            q_neg_d = bus.dividend[31] ^ bus.divisor[31];
            r_neg_d = bus.dividend[31];
            dbz_d   = bus.divisor == '0;
            state_d = dbz_d ? DONE : CALC;
            if (dbz_d) begin
                quo_d = '1;
                rem_d = bus.dividend;
                ov_d  = 1'b1;
            end
        end else if (state_q == CALC) begin
            r_d   = ge ? diff : sh[32:0];
            q_d   = {q_q[30:0], ge};
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                quo_d   = q_neg_q ? -q_d : q_d;
                rem_d   = r_neg_q ? -r_d[31:0] : r_d[31:0];
                ov_d    = 1'b1;
                state_d = DONE;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            ov_d    = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            ov_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            ov_q    <= ov_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors against an arithmetic reference model of div_iter.
module tb_div_iter;
`ifdef DIV_ITER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_iter_if bus ();
    div_iter dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q, exp_r;
    logic        exp_z;
    logic        expect_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: 64-bit signed arithmetic truncates toward zero and absorbs the MIN/-1 overflow.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (expect_on && bus.out_valid) begin
            check("quotient", bus.quotient, exp_q);
            check("remainder", bus.remainder, exp_r);
            check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, exp_z});
            check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                          input int hold, input logic [31:0] lq, input logic [31:0] lr, input logic lz);
        logic [31:0] mq, mr;
        logic        mz;
        int          lat, n;
        model(a, b, mq, mr, mz);
        check("model_q", mq, lq);
        check("model_r", mr, lr);
        check("model_z", {31'd0, mz}, {31'd0, lz});
        n = mz ? 1 : (EARLY ? 32 - int'(s) : 32);
        @(negedge clk);
        check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.dvd_shift = s;
        bus.in_valid  = 1'b1;
        bus.out_ready = hold == 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0BAD_F00D;
        exp_q = mq;
        exp_r = mr;
        exp_z = mz;
        expect_on = 1'b1;
        lat = 0;
        while (lat < 100) begin
            if (lat > 0) begin
                @(posedge clk);
                #1;
            end
            lat++;
            if (lat == 1 && !mz) begin
                @(posedge clk);
                #1;
                lat++;
                lat--;
            end
            if (bus.out_valid) break;
        end
        check("latency", lat, n);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        check("quotient_kept", bus.quotient, mq);
        expect_on = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.dvd_shift = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op(32'd100, 32'd7, 5'd24, 0, 32'd14, 32'd2, 1'b0);
        run_op(-32'sd100, 32'd7, 5'd24, 0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_op(32'd100, -32'sd7, 5'd24, 0, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_op(-32'sd100, -32'sd7, 5'd24, 0, 32'd14, 32'hFFFF_FFFE, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, 32'h8000_0000, 32'd0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 5'd2, 0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 5'd31, 5, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'd16, 5'd0, 0, 32'h07FF_FFFF, 32'd15, 1'b0);
        run_op(-32'sd7, 32'd2, 5'd28, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'd3, 5'd0, 0, 32'hD555_5556, 32'hFFFF_FFFE, 1'b0);

        // Abort 1000/3 mid-iteration; nothing may come out afterwards.
        @(negedge clk);
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        bus.dvd_shift = 5'd21;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_abort_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("abort_no_valid", seen, 32'd0);
        end
        run_op(32'd9, 32'd3, 5'd27, 0, 32'd3, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
